// File: rtl/graph_pkg.sv
// graph_pkg: definitions shared by the graph loader, the PageRank top level
// and the bench.
//   load_state_e : loader state encoding (IDLE, LOAD_ADJ, LOAD_WGT, DONE)
//   IN_W         : stream word width (fixed at 16 bits)
//   CNT_W        : width of the word_cnt output
//   ADJ_WORDS    : adjacency words per load at the default node count
//   TOTAL_WORDS  : adjacency words plus weight words at the default node count
// Modules with a non-default M derive their own counts from adj_words() and
// total_words(). Those counts must fit in CNT_W bits.
package graph_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_ADJ = 2'd1,
    LOAD_WGT = 2'd2,
    DONE     = 2'd3
  } load_state_e;

  localparam int IN_W      = 16;
  localparam int CNT_W     = 9;
  localparam int M_DEFAULT = 64;

  localparam int ADJ_WORDS   = M_DEFAULT * M_DEFAULT / IN_W;  // 256
  localparam int TOTAL_WORDS = ADJ_WORDS + M_DEFAULT;         // 320

  function automatic int adj_words(input int m);
    return m * m / IN_W;
  endfunction

  function automatic int total_words(input int m);
    return adj_words(m) + m;
  endfunction

endpackage

// File: rtl/loader_ctrl.sv
// loader_ctrl: control state machine and word counter for graph_loader.
//   clk_i, rst_ni  : clock and asynchronous active-low reset
//   start_i        : begins or restarts a load
//   in_valid_i     : upstream word is valid
//   in_ready_o     : a word is accepted this cycle if in_valid_i is also high
//   state_o        : current state, also used for debug visibility
//   word_cnt_o     : number of words accepted in the current load
//   wr_en_o        : write strobe, high on every accepted word
//   core_reset_o   : downstream core reset, low only in DONE
//   load_done_o    : one-cycle pulse on entry to DONE
//   loaded_o       : level signal, high while the completed load is stable
//
// Handshake: a word transfers on a rising edge where in_valid_i && in_ready_o.
// in_ready_o is forced low while start_i is high. As a result, start wins
// over a coincident word, and that word is dropped.
module loader_ctrl
  import graph_pkg::*;
#(
  parameter int M = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output load_state_e      state_o,
  output logic [CNT_W-1:0] word_cnt_o,
  output logic             wr_en_o,
  output logic             core_reset_o,
  output logic             load_done_o,
  output logic             loaded_o
);

  localparam int ADJ_N = M * M / IN_W;
  localparam int TOT_N = ADJ_N + M;
  localparam logic [CNT_W-1:0] ADJ_LAST = CNT_W'(ADJ_N - 1);
  localparam logic [CNT_W-1:0] TOT_LAST = CNT_W'(TOT_N - 1);

  load_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             load_done_q;
  logic             loaded_q;
  logic             core_reset_q;
  logic             loading;
  logic             accept;

  assign loading    = (state_q == LOAD_ADJ) || (state_q == LOAD_WGT);
  assign in_ready_o = loading && !start_i;
  assign accept     = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      load_done_q  <= 1'b0;
      loaded_q     <= 1'b0;
      core_reset_q <= 1'b1;
    end else begin
      load_done_q <= 1'b0;
      if (start_i) begin
        // Start takes effect from any state. A load in progress restarts from word 0.
        state_q      <= LOAD_ADJ;
        cnt_q        <= '0;
        loaded_q     <= 1'b0;
        core_reset_q <= 1'b1;
      end else begin
        case (state_q)
          LOAD_ADJ: begin
            if (accept) begin
              cnt_q <= cnt_q + 1'b1;
              if (cnt_q == ADJ_LAST) state_q <= LOAD_WGT;
            end
          end
          LOAD_WGT: begin
            if (accept) begin
              cnt_q <= cnt_q + 1'b1;
              if (cnt_q == TOT_LAST) begin
                state_q      <= DONE;
                load_done_q  <= 1'b1;
                loaded_q     <= 1'b1;
                core_reset_q <= 1'b0;
              end
            end
          end
          default: ;  // IDLE and DONE hold until the next start
        endcase
      end
    end
  end

  assign state_o      = state_q;
  assign word_cnt_o   = cnt_q;
  assign wr_en_o      = accept;
  assign core_reset_o = core_reset_q;
  assign load_done_o  = load_done_q;
  assign loaded_o     = loaded_q;

endmodule

// File: rtl/graph_loader.sv
// graph_loader: loads an M-node graph from a 16-bit word stream.
// It first receives M*M/16 adjacency words, then M weight words.
//   clk, reset   : clock and asynchronous active-low reset
//   start        : one-cycle pulse that begins or restarts a load
//   in_data      : stream word
//   in_valid     : in_data is valid
//   in_ready     : loader accepts in_data this cycle
//   adj          : adjacency matrix; bit r*M+c set means an edge from node r to node c
//   nodeWeight   : node n occupies bits [n*WIDTH +: WIDTH]
//   core_reset   : downstream PageRank core reset, active high
//   load_done    : one-cycle pulse when the load completes
//   loaded       : level signal, high once the outputs hold a complete load
//   word_cnt     : number of words accepted in the current load
// WIDTH must be 16 or less. Weight words keep only in_data[WIDTH-1:0].
module graph_loader
  import graph_pkg::*;
#(
  parameter int M     = 64,
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [IN_W-1:0]    in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [M*M-1:0]     adj,
  output logic [M*WIDTH-1:0] nodeWeight,
  output logic               core_reset,
  output logic               load_done,
  output logic               loaded,
  output logic [CNT_W-1:0]   word_cnt
);

  localparam int ADJ_N = M * M / IN_W;

  load_state_e      state;
  logic             wr_en;
  logic [CNT_W-1:0] wgt_idx;
  logic [M*M-1:0]   adj_q;
  logic [M*WIDTH-1:0] wgt_q;

  loader_ctrl #(.M(M)) u_ctrl (
    .clk_i        (clk),
    .rst_ni       (reset),
    .start_i      (start),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .state_o      (state),
    .word_cnt_o   (word_cnt),
    .wr_en_o      (wr_en),
    .core_reset_o (core_reset),
    .load_done_o  (load_done),
    .loaded_o     (loaded)
  );

  // Weight words follow the adjacency words in the same count.
  assign wgt_idx = word_cnt - CNT_W'(ADJ_N);

  // Word k lands in adj[k*16 +: 16], with in_data bit 0 in the lowest bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      adj_q <= '0;
    end else if (wr_en && state == LOAD_ADJ) begin
      for (int k = 0; k < ADJ_N; k++) begin
        if (word_cnt == CNT_W'(k)) adj_q[k*IN_W +: IN_W] <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wgt_q <= '0;
    end else if (wr_en && state == LOAD_WGT) begin
      for (int w = 0; w < M; w++) begin
        if (wgt_idx == CNT_W'(w)) wgt_q[w*WIDTH +: WIDTH] <= in_data[WIDTH-1:0];
      end
    end
  end

  assign adj        = adj_q;
  assign nodeWeight = wgt_q;

endmodule

// File: doc/graph_loader.md
GRAPH_LOADER -- requirements
Module: graph_loader

Interface
REQ-001 The module SHALL have parameters M (default 64, node count) and WIDTH (default 16, node weight width); the input word width SHALL be fixed at 16 bits and M*M SHALL be a multiple of 16.
REQ-002 Ports SHALL be as follows, clock and reset first:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a graph load.
- in_data  in  16  stream word.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts in_data this cycle.
- adj  out  M*M  adjacency matrix; bit r*M+c set means edge from node r to node c.
- nodeWeight  out  M*WIDTH  node weights; node n occupies bits [n*WIDTH +: WIDTH].
- core_reset  out  1  active-high reset to the downstream PageRank core.
- load_done  out  1  one-cycle pulse when the load completes.
- loaded  out  1  level signal: the last load completed and the outputs are stable.
- word_cnt  out  9  number of words accepted in the current load.

Function
REQ-003 The loader SHALL use a state machine with states IDLE, LOAD_ADJ, LOAD_WGT and DONE.
REQ-004 From IDLE or DONE, start=1 SHALL move to LOAD_ADJ on the next edge, clear word_cnt and loaded, and assert core_reset.
REQ-005 A start pulse received in LOAD_ADJ or LOAD_WGT SHALL restart the load (word_cnt=0, state LOAD_ADJ); words accepted before the restart are overwritten by the new load.
REQ-006 in_ready SHALL be 1 only in LOAD_ADJ and LOAD_WGT, and SHALL be 0 in the cycle in which start=1.
REQ-007 A word SHALL be accepted only when in_valid and in_ready are both 1; in_valid with in_ready=0 SHALL have no effect.
REQ-008 In LOAD_ADJ, accepted word k (k = 0 .. M*M/16-1) SHALL be written to adj[k*16 +: 16], with in_data bit 0 written to the lowest bit of that slice.
REQ-009 After word M*M/16-1 is accepted (word 255 at M=64), the state SHALL move to LOAD_WGT.
REQ-010 In LOAD_WGT, accepted weight word w (w = 0 .. M-1) SHALL be written to nodeWeight[w*WIDTH +: WIDTH] from in_data[WIDTH-1:0].
REQ-011 If WIDTH < 16, the upper bits of in_data SHALL be ignored; WIDTH > 16 is unsupported.
REQ-012 After weight M-1 is accepted at cycle t, at edge t+1 the state SHALL be DONE, load_done SHALL be 1 for exactly one cycle, loaded SHALL be 1, and core_reset SHALL be 0.
REQ-013 word_cnt SHALL increment by 1 per accepted word, reach M*M/16+M (320 at M=64) in DONE, and hold that value until the next start.
REQ-014 core_reset SHALL be 1 in every state except DONE.
REQ-015 adj and nodeWeight SHALL change only on accepted words, and SHALL hold their values in DONE and IDLE.
REQ-016 Gaps in in_valid SHALL stall the load without losing or duplicating any word.
REQ-017 If start and an accepting handshake coincide, start SHALL take priority and the word SHALL be dropped (in_ready=0 per REQ-006).

Reset
REQ-018 While reset=0, the state SHALL be IDLE and the outputs SHALL be: adj=0, nodeWeight=0, word_cnt=0, in_ready=0, load_done=0, loaded=0, core_reset=1.
REQ-019 Reset asserted mid-load SHALL abort the load immediately and asynchronously; after reset releases, no load proceeds until a new start.

Structure
REQ-020 The state encoding and the derived constants ADJ_WORDS=M*M/16 and TOTAL_WORDS=ADJ_WORDS+M SHALL live in a shared package graph_pkg for reuse by the PageRank top level and the bench.
REQ-021 The control state machine and counter SHALL live in a single sub-module, loader_ctrl, which provides the state, word_cnt and a write strobe; the graph_loader top SHALL hold the adj and nodeWeight storage registers.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Reset, then start, then 320 back-to-back words (adj words 16'hFFFF, weights 16'h0100) -> adj all ones; each weight 16'h0100; load_done pulses one cycle after word 319; word_cnt=320; core_reset falls in the same cycle.
- Adj word 0 = 16'h0002, all other words 0 -> only adj[1] is set (edge from node 0 to node 1); weight w = w -> nodeWeight[w*16 +: 16] = w.
- in_valid toggled 1/0 every cycle during a full load -> results identical to the back-to-back case; completion after about 640 cycles.
- Start pulse after 100 words, then a full new load -> final contents match the second stream only; a single load_done pulse.
- reset dropped at word 150 -> all outputs at their reset values asynchronously; a new start reloads correctly.
- in_valid=1 in IDLE with no start -> in_ready=0, word_cnt stays 0, adj unchanged.
